gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor_if.sv | 40 ++++
 rtl/gshare_predictor.sv | 92 +++++++++
 tb/tb_gshare_predictor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if: bundles the prediction request/response, the branch
// resolution (training) port and the statistics counters of the gshare
// predictor.
//   master : fetch/resolve side; drives requests and updates, sees results
//   slave  : the predictor itself
//   predict_valid/predict_pc/ghr                  prediction request
//   predict_out_valid/predict_taken/predict_index registered prediction
//   update_valid/update_index/update_taken/update_mispredict  training
//   branch_count/mispredict_count                 saturating statistics
interface gshare_predictor_if #(
   parameter int IDX_W = 8,
   parameter int PC_W  = 32
);
   logic             predict_valid;
   logic [PC_W-1:0]  predict_pc;
   logic [IDX_W-1:0] ghr;
   logic             predict_out_valid;
   logic             predict_taken;
   logic [IDX_W-1:0] predict_index;
   logic             update_valid;
   logic [IDX_W-1:0] update_index;
   logic             update_taken;
   logic             update_mispredict;
   logic [15:0]      branch_count;
   logic [15:0]      mispredict_count;

   modport master (
      output predict_valid, predict_pc, ghr,
      output update_valid, update_index, update_taken, update_mispredict,
      input  predict_out_valid, predict_taken, predict_index,
      input  branch_count, mispredict_count
   );

   modport slave (
      input  predict_valid, predict_pc, ghr,
      input  update_valid, update_index, update_taken, update_mispredict,
      output predict_out_valid, predict_taken, predict_index,
      output branch_count, mispredict_count
   );
endinterface

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch predictor. The pattern history
// table (PHT) holds 2**IDX_W two-bit saturating counters indexed by
// PC[IDX_W+1:2] XOR GHR. A prediction is returned one cycle after the
// request; resolved branches train the indexed counter and are counted.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gshare_predictor_if slave (request, response, update, counters)
module gshare_predictor #(
   parameter int IDX_W = 8,
   parameter int PC_W  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   gshare_predictor_if.slave bus
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0]       pht [DEPTH];
   logic [IDX_W-1:0] pred_idx;
   logic [1:0]       upd_cur;
   logic [1:0]       upd_next;

   logic             out_valid_q;
   logic             out_taken_q;
   logic [IDX_W-1:0] out_index_q;
   logic [15:0]      branch_cnt_q;
   logic [15:0]      mispredict_cnt_q;

   // PC bits below the word offset and above the index field do not
   // contribute to the index.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.predict_pc[PC_W-1:IDX_W+2], bus.predict_pc[1:0]};

   assign pred_idx = bus.predict_pc[IDX_W+1:2] ^ bus.ghr;

   // Saturating 2-bit counter step for the entry being trained.
   always_comb begin
      upd_cur  = pht[bus.update_index];
      upd_next = upd_cur;
      if (bus.update_taken) begin
         if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
      end else begin
         if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
      end
   end

   // NOTE: the table is built from flops and must come out of reset as
   // weakly-not-taken, so every entry is reset explicitly; this keeps it
   // out of a RAM macro, which cannot be cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pht[i] <= 2'b01;
      end else if (bus.update_valid) begin
         pht[bus.update_index] <= upd_next;
      end
   end

   // NOTE: non-blocking assignments make a same-cycle predict and update of
   // one entry read the pre-update counter (read-before-write) for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_taken_q <= 1'b0;
         out_index_q <= '0;
      end else begin
         out_valid_q <= bus.predict_valid;
         if (bus.predict_valid) begin
            out_taken_q <= pht[pred_idx][1];
            out_index_q <= pred_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else if (bus.update_valid) begin
         if (branch_cnt_q != 16'hFFFF) branch_cnt_q <= branch_cnt_q + 16'd1;
         if (bus.update_mispredict && (mispredict_cnt_q != 16'hFFFF))
            mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
      end
   end

   assign bus.predict_out_valid = out_valid_q;
   assign bus.predict_taken     = out_taken_q;
   assign bus.predict_index     = out_index_q;
   assign bus.branch_count      = branch_cnt_q;
   assign bus.mispredict_count  = mispredict_cnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed scoreboard bench for gshare_predictor.
// Stimulus pushes the expected prediction (due cycle, taken, index) into a
// queue; an independent monitor pops and compares on every output pulse.
module tb_gshare_predictor;

   localparam int IDX_W = 8;
   localparam int PC_W  = 32;

   typedef struct {
      int         due;
      logic       taken;
      logic [7:0] idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   exp_branch = 0;
   int   exp_mis = 0;
   exp_t sb[$];

   gshare_predictor_if #(.IDX_W(IDX_W), .PC_W(PC_W)) bus ();

   gshare_predictor #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Request a prediction this cycle and record what must come back.
   task automatic set_pred(input logic [31:0] pc, input logic [7:0] g,
                           input logic et, input logic [7:0] ei);
      exp_t e;
      bus.predict_valid = 1'b1;
      bus.predict_pc    = pc;
      bus.ghr           = g;
      e.due   = cyc + 1;
      e.taken = et;
      e.idx   = ei;
      sb.push_back(e);
   endtask

   task automatic set_upd(input logic [7:0] idx, input logic t, input logic m);
      bus.update_valid      = 1'b1;
      bus.update_index      = idx;
      bus.update_taken      = t;
      bus.update_mispredict = m;
      if (exp_branch < 16'hFFFF) exp_branch++;
      if (m && exp_mis < 16'hFFFF) exp_mis++;
   endtask

   // Advance one clock and return all strobes to idle.
   task automatic cycle();
      @(posedge clk);
      #1;
      bus.predict_valid     = 1'b0;
      bus.update_valid      = 1'b0;
      bus.update_mispredict = 1'b0;
   endtask

   // Monitor: compare every output pulse against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.predict_out_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pulse: index 0x%0h at cycle %0d, expected no pulse",
                        bus.predict_index, cyc);
            end else begin
               e = sb.pop_front();
               check("pred_latency", cyc, e.due);
               check("pred_taken", {31'b0, bus.predict_taken}, {31'b0, e.taken});
               check("pred_index", {24'b0, bus.predict_index}, {24'b0, e.idx});
            end
         end else if (rst_n && sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            $display("FAIL missed_pulse: no output at cycle %0d, expected index 0x%0h due %0d",
                     cyc, e.idx, e.due);
         end
      end
   end

   logic [7:0] stream_idx [10];

   initial begin
      stream_idx = '{8'h4F, 8'h4E, 8'h4D, 8'h4C, 8'h4B, 8'h4A, 8'h49, 8'h48, 8'h47, 8'h46};
      bus.predict_valid     = 1'b0;
      bus.predict_pc        = '0;
      bus.ghr               = '0;
      bus.update_valid      = 1'b0;
      bus.update_index      = '0;
      bus.update_taken      = 1'b0;
      bus.update_mispredict = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, bus.predict_out_valid}, 32'd0);
      check("rst_taken", {31'b0, bus.predict_taken}, 32'd0);
      check("rst_index", {24'b0, bus.predict_index}, 32'd0);
      check("rst_branch_count", {16'b0, bus.branch_count}, 32'd0);
      check("rst_mispredict_count", {16'b0, bus.mispredict_count}, 32'd0);

      // First edge after release: request and update both processed
      rst_n = 1'b1;
      set_pred(32'h10, 8'h00, 1'b0, 8'h04);
      set_upd(8'h20, 1'b1, 1'b0);
      cycle();
      cycle();

      // Training of entry 0x04 including both saturation limits
      set_upd(8'h04, 1'b1, 1'b0); cycle();
      set_upd(8'h04, 1'b1, 1'b1); cycle();
      set_pred(32'h10, 8'h00, 1'b1, 8'h04); cycle();   // 11
      set_upd(8'h04, 1'b1, 1'b0); cycle();
      set_upd(8'h04, 1'b1, 1'b0); cycle();              // stays 11
      set_upd(8'h04, 1'b0, 1'b1); cycle();
      set_pred(32'h10, 8'h00, 1'b1, 8'h04); cycle();   // 10
      set_upd(8'h04, 1'b0, 1'b1); cycle();
      set_pred(32'h10, 8'h00, 1'b0, 8'h04); cycle();   // 01
      set_upd(8'h04, 1'b0, 1'b0); cycle();
      set_upd(8'h04, 1'b0, 1'b0); cycle();              // stays 00
      set_upd(8'h04, 1'b1, 1'b0); cycle();
      set_pred(32'h10, 8'h00, 1'b0, 8'h04); cycle();   // 01
      set_upd(8'h04, 1'b1, 1'b0); cycle();
      set_pred(32'h10, 8'h00, 1'b1, 8'h04); cycle();   // 10

      // Mispredict flag without update_valid must not count
      bus.update_mispredict = 1'b1;
      cycle();
      check("branch_count_train", {16'b0, bus.branch_count}, exp_branch);
      check("mispredict_count_train", {16'b0, bus.mispredict_count}, exp_mis);

      // Index formation, back to back
      set_pred(32'h10, 8'hFF, 1'b0, 8'hFB); cycle();
      set_pred(32'h3FC, 8'h00, 1'b0, 8'hFF); cycle();
      set_pred(32'h13, 8'h00, 1'b1, 8'h04); cycle();   // low PC bits ignored

      // Same-index predict and update: read-before-write
      set_upd(8'h04, 1'b0, 1'b0); cycle();              // 01
      set_pred(32'h10, 8'h00, 1'b0, 8'h04);
      set_upd(8'h04, 1'b1, 1'b0); cycle();              // predicts 0, becomes 10
      set_pred(32'h10, 8'h00, 1'b1, 8'h04); cycle();

      // Different-index predict and update in one cycle
      set_pred(32'h14, 8'h00, 1'b0, 8'h05);
      set_upd(8'h04, 1'b0, 1'b0); cycle();              // entry 4 -> 01
      set_pred(32'h10, 8'h00, 1'b0, 8'h04);
      set_upd(8'h05, 1'b1, 1'b0); cycle();              // entry 5 -> 10
      set_pred(32'h14, 8'h00, 1'b1, 8'h05); cycle();
      cycle();

      // Ten back-to-back requests with varying PC
      set_upd(8'h4A, 1'b1, 1'b0); cycle();
      for (int i = 0; i < 10; i++) begin
         set_pred(32'h100 + 32'(4 * i), 8'h0F, (i == 5), stream_idx[i]);
         cycle();
      end
      cycle();
      cycle();
      check("sb_drained_stream", sb.size(), 32'd0);
      check("branch_count_mid", {16'b0, bus.branch_count}, exp_branch);

      // Long update stream saturates both counters
      bus.update_valid      = 1'b1;
      bus.update_index      = 8'h04;
      bus.update_taken      = 1'b1;
      bus.update_mispredict = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      check("branch_count_sat", {16'b0, bus.branch_count}, 32'h0000FFFF);
      check("mispredict_count_sat", {16'b0, bus.mispredict_count}, 32'h0000FFFF);

      // Asynchronous reset with a prediction in flight
      bus.predict_valid = 1'b1;
      bus.predict_pc    = 32'h10;
      bus.ghr           = 8'h00;
      @(posedge clk);
      #1;
      bus.predict_valid = 1'b0;
      check("inflight_valid", {31'b0, bus.predict_out_valid}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      exp_branch = 0;
      exp_mis    = 0;
      check("async_out_valid", {31'b0, bus.predict_out_valid}, 32'd0);
      check("async_taken", {31'b0, bus.predict_taken}, 32'd0);
      check("async_index", {24'b0, bus.predict_index}, 32'd0);
      check("async_branch_count", {16'b0, bus.branch_count}, 32'd0);
      check("async_mispredict_count", {16'b0, bus.mispredict_count}, 32'd0);
      bus.update_valid      = 1'b0;
      bus.update_mispredict = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table back at 01 after reset
      set_pred(32'h10, 8'h00, 1'b0, 8'h04); cycle();
      set_upd(8'h04, 1'b1, 1'b0); cycle();
      set_pred(32'h10, 8'h00, 1'b1, 8'h04); cycle();
      set_pred(32'h128, 8'h00, 1'b0, 8'h4A); cycle();
      cycle();
      cycle();
      check("sb_drained_final", sb.size(), 32'd0);
      check("branch_count_final", {16'b0, bus.branch_count}, exp_branch);
      check("mispredict_count_final", {16'b0, bus.mispredict_count}, exp_mis);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
